// File: rtl/lives_controller.sv
// Player life-count sequencer: damage/extra-life handling, post-hit invulnerability
// window counted in frame ticks, sprite blink during the window, and game-over.
module lives_controller #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned MAX_LIVES     = 3,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       extra_life,
  input  logic       frame_tick,
  output logic [3:0] lives,
  output logic       invuln,
  output logic       blink,
  output logic       hit_ack,
  output logic       gameover
);

  localparam int unsigned FRAME_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(INVULN_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [3:0] LIVES_START = 4'(START_LIVES);
  localparam logic [3:0] LIVES_MAX   = 4'(MAX_LIVES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_INVULN = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  state_t             r_state;
  logic [3:0]         r_lives;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_invuln;
  logic               r_blink;
  logic               r_hit_ack;
  logic               r_gameover;

  logic [3:0] w_lives_inc;
  logic [3:0] w_lives_dec;
  logic [3:0] w_lives_hit_xl;

  // Saturating increment/decrement; a hit paired with a pickup only costs a life at the ceiling.
  assign w_lives_inc    = (r_lives >= LIVES_MAX) ? LIVES_MAX : r_lives + 4'd1;
  assign w_lives_dec    = (r_lives == 4'd0) ? 4'd0 : r_lives - 4'd1;
  assign w_lives_hit_xl = (r_lives >= LIVES_MAX) ? w_lives_dec : r_lives;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lives     <= 4'd0;
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      r_invuln    <= 1'b0;
      r_blink     <= 1'b0;
      r_hit_ack   <= 1'b0;
      r_gameover  <= 1'b0;
    end else begin
      r_hit_ack <= 1'b0;
      if (start) begin
        r_state     <= S_PLAY;
        r_lives     <= LIVES_START;
        r_frame_cnt <= '0;
        r_blink_cnt <= '0;
        r_invuln    <= 1'b0;
        r_blink     <= 1'b0;
        r_gameover  <= 1'b0;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (hit) begin
              r_hit_ack   <= 1'b1;
              r_frame_cnt <= '0;
              r_blink_cnt <= '0;
              r_blink     <= 1'b0;
              if (extra_life) begin
                r_lives  <= w_lives_hit_xl;
                r_state  <= S_INVULN;
                r_invuln <= 1'b1;
              end else if (w_lives_dec == 4'd0) begin
                r_lives    <= 4'd0;
                r_state    <= S_DEAD;
                r_gameover <= 1'b1;
              end else begin
                r_lives  <= w_lives_dec;
                r_state  <= S_INVULN;
                r_invuln <= 1'b1;
              end
            end else if (extra_life) begin
              r_lives <= w_lives_inc;
            end
          end
          S_INVULN: begin
            if (extra_life) begin
              r_lives <= w_lives_inc;
            end
            if (frame_tick) begin
              if (r_frame_cnt == FRAME_LAST) begin
                r_state     <= S_PLAY;
                r_invuln    <= 1'b0;
                r_blink     <= 1'b0;
                r_frame_cnt <= '0;
                r_blink_cnt <= '0;
              end else begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
                if (r_blink_cnt == BLINK_LAST) begin
                  r_blink     <= ~r_blink;
                  r_blink_cnt <= '0;
                end else begin
                  r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign lives    = r_lives;
  assign invuln   = r_invuln;
  assign blink    = r_blink;
  assign hit_ack  = r_hit_ack;
  assign gameover = r_gameover;

endmodule
